// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like port between fetch and data requesters,
// data-first with a fetch starvation guard, locked grants and in-order response routing.
module sram_port_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [31:0] sram_addr,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata,
    output logic        protocol_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic {UNLOCKED, LOCKED} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [DEPTH-1:0] fifo_q;
    logic [AW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;
    logic            grant_data, grant_inst, full, empty, push, pop, head;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= UNLOCKED;
            owner_q  <= 1'b0;
            starve_q <= '0;
            fifo_q   <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            if (push) begin
                fifo_q[wp_q] <= grant_data;
                wp_q         <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (sram_data_ok && empty) err_q <= 1'b1;
        end
    end

    // A locked grant sticks to the latched owner until the downstream accepts it.
    always_comb begin
        grant_data = (state_q == LOCKED) ? owner_q
                   : data_req & ~(inst_req & (starve_q == STARVE_TOP));
        grant_inst = ~grant_data & ((state_q == LOCKED) | inst_req);
        full       = cnt_q == FULL_CNT;
        empty      = cnt_q == '0;
        sram_req   = (grant_data ? data_req : grant_inst & inst_req) & ~full;
        push       = sram_req & sram_addr_ok;
        pop        = sram_data_ok & ~empty;
        head       = fifo_q[rp_q];
    end

    always_comb begin
        state_d  = (sram_req & ~sram_addr_ok) ? LOCKED : UNLOCKED;
        owner_d  = grant_data;
        starve_d = (~inst_req | (push & grant_inst)) ? '0
                 : (grant_data & (state_q == UNLOCKED) & (starve_q != STARVE_TOP)) ? starve_q + 1'b1
                 : starve_q;
    end

    always_comb begin
        sram_wr      = grant_data ? data_wr    : grant_inst & inst_wr;
        sram_size    = grant_data ? data_size  : grant_inst ? inst_size  : '0;
        sram_addr    = grant_data ? data_addr  : grant_inst ? inst_addr  : '0;
        sram_wstrb   = grant_data ? data_wstrb : grant_inst ? inst_wstrb : '0;
        sram_wdata   = grant_data ? data_wdata : grant_inst ? inst_wdata : '0;
        inst_addr_ok = push & grant_inst;
        data_addr_ok = push & grant_data;
        inst_data_ok = pop & ~head;
        data_data_ok = pop & head;
        inst_rdata   = sram_rdata;
        data_rdata   = sram_rdata;
        protocol_err = err_q;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_sram_port_arbiter;
    localparam int D  = 4;
    localparam int SM = 8;

    logic        clk = 1'b0, reset = 1'b1;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, sram_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, inst_rdata, data_rdata;
    logic [3:0]  inst_wstrb, data_wstrb, sram_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        sram_req, sram_wr, sram_addr_ok, sram_data_ok, protocol_err;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    sram_port_arbiter #(.DEPTH(D), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
        .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
        .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [127:0] g, x;

    // Reference model: outstanding owners as a queue, grant rules straight from the arbitration text.
    typedef struct packed {logic gd, gi, sreq, acc, pop, idok, ddok;} exp_t;
    logic m_lock = 1'b0, m_own = 1'b0, m_err = 1'b0;
    int   m_starve = 0;
    logic m_q[$];

    function automatic exp_t model_eval();
        exp_t e;
        e.gd   = m_lock ? m_own : (data_req && !(m_starve == SM && inst_req));
        e.gi   = !e.gd && (m_lock || inst_req);
        e.sreq = (e.gd ? data_req : (e.gi && inst_req)) && (m_q.size() < D);
        e.acc  = e.sreq && sram_addr_ok;
        e.pop  = sram_data_ok && (m_q.size() > 0);
        e.idok = e.pop && (m_q[0] == 1'b0);
        e.ddok = e.pop && (m_q[0] == 1'b1);
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        e = model_eval();
        if (reset) begin
            m_q.delete(); m_lock = 1'b0; m_own = 1'b0; m_starve = 0; m_err = 1'b0;
        end else begin
            if (sram_data_ok && m_q.size() == 0) m_err = 1'b1;
            if (!inst_req || (e.acc && e.gi)) m_starve = 0;
            else if (e.gd && !m_lock && m_starve < SM) m_starve++;
            if (e.pop) void'(m_q.pop_front());
            if (e.acc) m_q.push_back(e.gd);
            m_lock = e.sreq && !sram_addr_ok;
            m_own  = e.gd;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = 0;
    endtask

    task automatic test_reset();
        idle(); reset = 1; tick(); tick(); reset = 0;
        @(negedge clk);
        g = {sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata, inst_addr_ok,
             data_addr_ok, inst_data_ok, data_data_ok, protocol_err, inst_rdata, data_rdata};
        x = '0;
        checks++; if (g !== x) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", g, x); end
        tick();
    endtask

    task automatic test_basic_read();
        inst_req = 1; inst_addr = 32'h1C00_0000; sram_addr_ok = 1;
        @(negedge clk);
        g = {sram_req, inst_addr_ok, data_addr_ok, sram_addr}; x = {3'b110, 32'h1C00_0000};
        checks++; if (g !== x) begin errors++; $display("FAIL basic_accept got=%h exp=%h", g, x); end
        tick();
        inst_req = 0; inst_addr = 0; sram_addr_ok = 0;
        @(negedge clk);
        g = {sram_req, inst_addr_ok, inst_data_ok, data_data_ok}; x = 0;
        checks++; if (g !== x) begin errors++; $display("FAIL basic_gap got=%h exp=%h", g, x); end
        tick();
        sram_data_ok = 1; sram_rdata = 32'h0280_0C0C;
        @(negedge clk);
        g = {inst_data_ok, data_data_ok, data_addr_ok, protocol_err, inst_rdata}; x = {4'b1000, 32'h0280_0C0C};
        checks++; if (g !== x) begin errors++; $display("FAIL basic_response got=%h exp=%h", g, x); end
        tick();
        idle();
        @(negedge clk);
        g = {inst_data_ok, protocol_err}; x = 0;
        checks++; if (g !== x) begin errors++; $display("FAIL basic_after got=%h exp=%h", g, x); end
        tick();
    endtask

    task automatic test_priority_lock();
        inst_req = 1; inst_addr = 32'hA000_0000; data_req = 1; data_addr = 32'hD000_0040;
        data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) inst_req = 0;
            if (c == 2) inst_req = 1;
            sram_addr_ok = (c == 3);
            @(negedge clk);
            g = {sram_req, sram_wr, sram_addr, sram_wdata, data_addr_ok, inst_addr_ok};
            x = {2'b11, 32'hD000_0040, 32'h1234_5678, (c == 3), 1'b0};
            checks++; if (g !== x) begin errors++; $display("FAIL lock_hold c=%0d got=%h exp=%h", c, g, x); end
            tick();
        end
        data_req = 0; data_wr = 0; data_wstrb = 0; data_wdata = 0; data_addr = 0; sram_addr_ok = 1;
        @(negedge clk);
        g = {sram_addr, sram_wr, inst_addr_ok, data_addr_ok}; x = {32'hA000_0000, 3'b010};
        checks++; if (g !== x) begin errors++; $display("FAIL lock_fetch_next got=%h exp=%h", g, x); end
        tick();
        inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            g = {data_data_ok, inst_data_ok}; x = (c == 0) ? 2'b10 : 2'b01;
            checks++; if (g !== x) begin errors++; $display("FAIL lock_drain c=%0d got=%h exp=%h", c, g, x); end
            tick();
        end
        idle();
    endtask

    task automatic test_ordering();
        inst_req = 1; inst_addr = 32'h0000_0A00; sram_addr_ok = 1;
        @(negedge clk);
        g = {inst_addr_ok, data_addr_ok}; x = 2'b10;
        checks++; if (g !== x) begin errors++; $display("FAIL order_a got=%h exp=%h", g, x); end
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h0000_0B00; sram_data_ok = 1; sram_rdata = 1;
        @(negedge clk);
        g = {data_addr_ok, inst_data_ok, data_data_ok, inst_rdata}; x = {3'b110, 32'd1};
        checks++; if (g !== x) begin errors++; $display("FAIL order_b got=%h exp=%h", g, x); end
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'h0000_0C00; sram_rdata = 2;
        @(negedge clk);
        g = {inst_addr_ok, inst_data_ok, data_data_ok, data_rdata}; x = {3'b101, 32'd2};
        checks++; if (g !== x) begin errors++; $display("FAIL order_c got=%h exp=%h", g, x); end
        tick();
        inst_req = 0; sram_addr_ok = 0; sram_rdata = 3;
        @(negedge clk);
        g = {inst_data_ok, data_data_ok, inst_rdata}; x = {2'b10, 32'd3};
        checks++; if (g !== x) begin errors++; $display("FAIL order_last got=%h exp=%h", g, x); end
        tick();
        idle();
    endtask

    task automatic test_full_fifo();
        data_req = 1; sram_addr_ok = 1;
        for (int c = 0; c < D; c++) begin
            data_addr = 32'h100 + 32'(c * 4);
            @(negedge clk);
            g = {sram_req, data_addr_ok}; x = 2'b11;
            checks++; if (g !== x) begin errors++; $display("FAIL full_fill c=%0d got=%h exp=%h", c, g, x); end
            tick();
        end
        sram_data_ok = 1; sram_rdata = 32'hF0;
        @(negedge clk);
        g = {sram_req, data_addr_ok, data_data_ok}; x = 3'b001;
        checks++; if (g !== x) begin errors++; $display("FAIL full_block got=%h exp=%h", g, x); end
        tick();
        sram_data_ok = 0;
        @(negedge clk);
        g = {sram_req, data_addr_ok}; x = 2'b11;
        checks++; if (g !== x) begin errors++; $display("FAIL full_resume got=%h exp=%h", g, x); end
        tick();
        data_req = 0; sram_addr_ok = 0; sram_data_ok = 1;
        for (int c = 0; c < D; c++) begin
            @(negedge clk);
            g = {data_data_ok, inst_data_ok}; x = 2'b10;
            checks++; if (g !== x) begin errors++; $display("FAIL full_drain c=%0d got=%h exp=%h", c, g, x); end
            tick();
        end
        idle();
    endtask

    task automatic test_starvation();
        data_req = 1; data_addr = 32'h2000; inst_req = 1; inst_addr = 32'h1000; sram_addr_ok = 1;
        for (int k = 0; k < SM + 2; k++) begin
            sram_data_ok = (k > 0);
            @(negedge clk);
            g = {inst_addr_ok, data_addr_ok}; x = (k == SM) ? 2'b10 : 2'b01;
            checks++; if (g !== x) begin errors++; $display("FAIL starve_grant k=%0d got=%h exp=%h", k, g, x); end
            if (k > 0) begin
                g = {inst_data_ok, data_data_ok}; x = (k == SM + 1) ? 2'b10 : 2'b01;
                checks++; if (g !== x) begin errors++; $display("FAIL starve_resp k=%0d got=%h exp=%h", k, g, x); end
            end
            tick();
        end
        inst_req = 0; data_req = 0; sram_addr_ok = 0; sram_data_ok = 1;
        @(negedge clk);
        g = {inst_data_ok, data_data_ok, protocol_err}; x = 3'b010;
        checks++; if (g !== x) begin errors++; $display("FAIL starve_drain got=%h exp=%h", g, x); end
        tick();
        idle();
    endtask

    task automatic test_spurious_reset();
        sram_data_ok = 1; sram_rdata = 32'hBAD;
        @(negedge clk);
        g = {inst_data_ok, data_data_ok, protocol_err}; x = 0;
        checks++; if (g !== x) begin errors++; $display("FAIL spur_drop got=%h exp=%h", g, x); end
        tick();
        sram_data_ok = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL spur_sticky c=%0d got=%b exp=1", c, protocol_err); end
            tick();
        end
        inst_req = 1; inst_addr = 32'h40; sram_addr_ok = 1;
        tick();
        idle(); reset = 1; tick(); reset = 0;
        @(negedge clk);
        g = {protocol_err, sram_req, inst_data_ok}; x = 0;
        checks++; if (g !== x) begin errors++; $display("FAIL spur_reset got=%h exp=%h", g, x); end
        tick();
        sram_data_ok = 1;
        @(negedge clk);
        g = {inst_data_ok, data_data_ok}; x = 0;
        checks++; if (g !== x) begin errors++; $display("FAIL reset_discard got=%h exp=%h", g, x); end
        tick();
        sram_data_ok = 0;
        @(negedge clk);
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL reset_discard_err got=%b exp=1", protocol_err); end
        reset = 1; tick(); reset = 0;
    endtask

    task automatic test_random();
        exp_t e;
        logic ip, dp;
        logic [31:0] ea, ew;
        ip = 0; dp = 0;
        for (int n = 0; n < 600; n++) begin
            if (!ip && $urandom_range(2) == 0) begin
                ip = 1; inst_addr = $urandom; inst_wr = 1'($urandom_range(1)); inst_size = 2'($urandom);
                inst_wstrb = 4'($urandom); inst_wdata = $urandom;
            end
            if (!dp && $urandom_range(2) == 0) begin
                dp = 1; data_addr = $urandom; data_wr = 1'($urandom_range(1)); data_size = 2'($urandom);
                data_wstrb = 4'($urandom); data_wdata = $urandom;
            end
            inst_req = ip; data_req = dp;
            sram_addr_ok = 1'($urandom_range(1));
            sram_data_ok = (m_q.size() > 0) && ($urandom_range(2) == 0);
            sram_rdata = $urandom;
            @(negedge clk);
            e  = model_eval();
            ea = e.gd ? data_addr : e.gi ? inst_addr : 32'h0;
            ew = e.gd ? data_wdata : e.gi ? inst_wdata : 32'h0;
            g = {sram_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, protocol_err,
                 sram_addr, sram_wdata, inst_rdata, data_rdata};
            x = {e.sreq, e.acc && e.gi, e.acc && e.gd, e.idok, e.ddok, m_err, ea, ew, sram_rdata, sram_rdata};
            checks++; if (g !== x) begin errors++; $display("FAIL random n=%0d got=%h exp=%h", n, g, x); end
            if (e.acc && e.gi) ip = 0;
            if (e.acc && e.gd) dp = 0;
            tick();
        end
        idle();
        for (int n = 0; n < 2 * D && m_q.size() > 0; n++) begin
            sram_data_ok = 1;
            @(negedge clk);
            e = model_eval();
            g = {inst_data_ok, data_data_ok}; x = {e.idok, e.ddok};
            checks++; if (g !== x) begin errors++; $display("FAIL random_drain n=%0d got=%h exp=%h", n, g, x); end
            tick();
        end
        idle();
        @(negedge clk);
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL random_err got=%b exp=0", protocol_err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_priority_lock();
        test_ordering();
        test_full_fifo();
        test_starvation();
        test_spurious_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
